// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single-ported data memory: IDLE -> ACCESS -> RESP per transfer.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build gives port 0 fixed priority.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [3:0]            be0,
    input  logic [3:0]            be1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_write,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                  state_q;
    logic                    gnt_q;
    logic                    we_q;
    logic                    oor_q;
    logic [1:0]              ack_q;
    logic [1:0]              err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic [3:0]              mem_write_q;
    logic [DATA_WIDTH-1:0]   mem_write_data_q;
    logic                    mem_read_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                    last_grant_q;
`endif

    logic                    gnt_d;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_we;
    logic [3:0]              sel_be;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_oor;

    always_comb begin
        gnt_d = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            gnt_d = ~last_grant_q;
        end else begin
            gnt_d = req1;
        end
`else
        gnt_d = ~req0;
`endif
    end

    assign sel_addr  = gnt_d ? addr1  : addr0;
    assign sel_we    = gnt_d ? we1    : we0;
    assign sel_be    = gnt_d ? be1    : be0;
    assign sel_wdata = gnt_d ? wdata1 : wdata0;
    assign sel_oor   = {1'b0, sel_addr} >= DEPTH_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            gnt_q            <= 1'b0;
            we_q             <= 1'b0;
            oor_q            <= 1'b0;
            ack_q            <= 2'b00;
            err_q            <= 2'b00;
            rdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_q      <= 4'b0000;
            mem_write_data_q <= '0;
            mem_read_q       <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q     <= 1'b1;
`endif
        end else begin
            ack_q <= 2'b00;
            err_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q          <= ACCESS;
                        gnt_q            <= gnt_d;
                        we_q             <= sel_we;
                        oor_q            <= sel_oor;
                        mem_address_q    <= sel_addr;
                        mem_write_data_q <= sel_wdata;
                        // Strobes are launched with the grant so they line up exactly with ACCESS.
                        mem_write_q      <= (sel_we && !sel_oor) ? sel_be : 4'b0000;
                        mem_read_q       <= !sel_we && !sel_oor;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_grant_q     <= gnt_d;
`endif
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    mem_write_q <= 4'b0000;
                    mem_read_q  <= 1'b0;
                    if (oor_q) begin
                        rdata_q <= '0;
                    end else if (!we_q) begin
                        rdata_q <= mem_read_data;
                    end
                    ack_q[gnt_q] <= 1'b1;
                    err_q[gnt_q] <= oor_q;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0           = ack_q[0];
    assign ack1           = ack_q[1];
    assign err0           = err_q[0];
    assign err1           = err_q[1];
    assign rdata          = rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_write      = mem_write_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_read       = mem_read_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: timeline model of grants checked every cycle, plus directed transfers with literal results.
module tb_data_mem_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]  addr0 = '0, addr1 = '0;
    logic [3:0]     be0 = '0, be1 = '0;
    logic [DW-1:0]  wdata0 = '0, wdata1 = '0;
    logic           ack0, ack1, err0, err1, mem_read, busy;
    logic [DW-1:0]  rdata, mem_write_data, mem_read_data;
    logic [AW-1:0]  mem_address;
    logic [3:0]     mem_write;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .be0(be0), .be1(be1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_address(mem_address), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    // Environment memory: combinational read, byte-strobed synchronous write.
    logic [DW-1:0] mem [DEPTH];
    logic          preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[16] <= 32'hDEADBEEF;
            mem[32] <= 32'hAAAAAAAA;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write[b] && mem_address < AW'(DEPTH))
                    mem[mem_address[7:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
    end

    assign mem_read_data = (mem_address < AW'(DEPTH)) ? mem[mem_address[7:0]] : '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: a grant in cycle c means strobe in c+1, ack in c+2, next grant no earlier than c+3.
    bit            chk_en = 1'b0;
    int            cyc = 0;
    int            free_at = 0;
    int            t_start = 0;
    bit            have_txn = 1'b0;
    bit            t_port, t_we, t_oor;
    logic [3:0]    t_be;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] rd_exp = '0;
    bit            last_g = 1'b1;
    int            ack_log [$];

    logic          e_busy, e_rd;
    logic [1:0]    e_ack, e_err;
    logic [3:0]    e_wr;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = 1'b0; e_rd = 1'b0; e_wr = 4'h0; e_ack = 2'b00; e_err = 2'b00;
            if (have_txn && cyc == t_start + 1) begin
                e_busy = 1'b1;
                e_rd   = !t_we && !t_oor;
                e_wr   = (t_we && !t_oor) ? t_be : 4'h0;
                chk("mem_address", mem_address, t_addr);
                if (t_we) chk("mem_write_data", mem_write_data, t_wdata);
            end else if (have_txn && cyc == t_start + 2) begin
                e_busy        = 1'b1;
                e_ack[t_port] = 1'b1;
                e_err[t_port] = t_oor;
                if (t_oor) rd_exp = '0;
                else if (!t_we) rd_exp = mem[t_addr[7:0]];
                $display("txn port=%0d addr=%0h we=%0b err=%0b rdata=%0h", t_port, t_addr, t_we, t_oor, rd_exp);
                have_txn = 1'b0;
            end
            chk("busy", busy, e_busy);
            chk("ack0", ack0, e_ack[0]);
            chk("ack1", ack1, e_ack[1]);
            if (e_ack[0]) chk("err0", err0, e_err[0]);
            if (e_ack[1]) chk("err1", err1, e_err[1]);
            chk("mem_read", mem_read, e_rd);
            chk("mem_write", mem_write, e_wr);
            chk("rdata", rdata, rd_exp);
            if (ack0) ack_log.push_back(0);
            if (ack1) ack_log.push_back(1);

            if (reset) begin
                have_txn = 1'b0;
                rd_exp   = '0;
                last_g   = 1'b1;
                free_at  = cyc + 1;
            end else if (cyc >= free_at && (req0 || req1)) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (req0 && req1) t_port = !last_g;
                else t_port = req1;
`else
                t_port = !req0;
`endif
                last_g   = t_port;
                t_addr   = t_port ? addr1 : addr0;
                t_we     = t_port ? we1 : we0;
                t_be     = t_port ? be1 : be0;
                t_wdata  = t_port ? wdata1 : wdata0;
                t_oor    = t_addr >= AW'(DEPTH);
                have_txn = 1'b1;
                t_start  = cyc;
                free_at  = cyc + 3;
            end
            cyc++;
        end
    end

    task automatic do_access(input bit p, input logic [AW-1:0] a, input bit w, input logic [3:0] b,
                             input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic er,
                             output int lat);
        bit got;
        got = 1'b0; rd = '0; er = 1'b0; lat = 0;
        @(posedge clk); #1;
        if (p) begin req1 = 1'b1; addr1 = a; we1 = w; be1 = b; wdata1 = d; end
        else   begin req0 = 1'b1; addr0 = a; we0 = w; be0 = b; wdata0 = d; end
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            lat++;
            if ((p ? ack1 : ack0) === 1'b1) begin
                got = 1'b1;
                rd  = rdata;
                er  = p ? err1 : err0;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout port=%0d got=none want=ack", p);
        end
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    logic [DW-1:0] rd;
    logic          er;
    int            lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        reset   = 1'b0;
        chk_en  = 1'b1;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_err", {err1, err0}, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_write_data, 0);

        do_access(1'b0, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat);
        chk("rd0_data", rd, 32'hDEADBEEF);
        chk("rd0_err", er, 0);
        chk("rd0_lat", lat, 3);

        do_access(1'b1, 32'h20, 1'b1, 4'b0011, 32'h12345678, rd, er, lat);
        chk("wr1_rdata_kept", rd, 32'hDEADBEEF);
        chk("wr1_lat", lat, 3);

        do_access(1'b0, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat);
        chk("rb_byte_write", rd, 32'hAAAA5678);

        do_access(1'b0, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, rd, er, lat);
        do_access(1'b1, 32'h30, 1'b0, 4'h0, 32'h0, rd, er, lat);
        chk("rb_full_write", rd, 32'hCAFEF00D);
        chk("rb_full_err", er, 0);

        do_access(1'b0, AW'(DEPTH), 1'b0, 4'h0, 32'h0, rd, er, lat);
        chk("oor_err", er, 1);
        chk("oor_rdata", rd, 0);

        // Contention from a fresh reset, both ports held for 12 cycles.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        ack_log.delete();
        req0 = 1'b1; addr0 = 32'h10; we0 = 1'b0;
        req1 = 1'b1; addr1 = 32'h30; we1 = 1'b0;
        repeat (12) @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("cont_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size()) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                chk($sformatf("cont_ack%0d", i), ack_log[i], i % 2);
`else
                chk($sformatf("cont_ack%0d", i), ack_log[i], 0);
`endif
            end
        end

        // Reset while the write is in ACCESS: no ack, strobes gone next cycle.
        ack_log.delete();
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 32'h40; we0 = 1'b1; be0 = 4'hF; wdata0 = 32'h55AA55AA;
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        chk("mid_strobe", mem_write, 4'hF);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_mem_write", mem_write, 0);
        repeat (4) @(negedge clk);
        chk("mid_no_ack", ack_log.size(), 0);

        do_access(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat);
        chk("post_rst_data", rd, 32'hDEADBEEF);
        chk("post_rst_lat", lat, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
